// File: rtl/control_sequencer.sv
// control_sequencer
//   Micro-step sequencer for an 8-bit breadboard-style CPU. A step register walks
//   T0..T4; every control line is a combinational decode of the step, the opcode
//   and the ALU flags. The datapath latches on the rising edge that ends the step.
//
// Ports
//   i_CLOCK            system clock, rising edge
//   i_CLEAR            asynchronous active-high reset
//   i_OPCODE           instruction-register opcode, valid from T2
//   i_ZERO_FLAG        ALU zero flag (JZ)
//   i_CARRY_FLAG       ALU carry flag (JC)
//   o_PC_COUNT_ENABLE, o_OUT_READ_BUS, o_ALU_SUBTRACT, o_HALT   active-high controls
//   o_*_n              active-low bus/enable controls
//   o_STEP             current micro-step index for display
module control_sequencer #(
   parameter int unsigned OPCODE_WIDTH = 4
) (
   input  logic                    i_CLOCK,
   input  logic                    i_CLEAR,
   input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
   input  logic                    i_ZERO_FLAG,
   input  logic                    i_CARRY_FLAG,
   output logic                    o_PC_COUNT_ENABLE,
   output logic                    o_OUT_READ_BUS,
   output logic                    o_ALU_SUBTRACT,
   output logic                    o_HALT,
   output logic                    o_PC_JUMP_n,
   output logic                    o_PC_WRITE_BUS_n,
   output logic                    o_MAR_READ_BUS_n,
   output logic                    o_RAM_READ_BUS_n,
   output logic                    o_RAM_WRITE_BUS_n,
   output logic                    o_IR_READ_BUS_n,
   output logic                    o_IR_WRITE_BUS_n,
   output logic                    o_A_READ_BUS_n,
   output logic                    o_A_WRITE_BUS_n,
   output logic                    o_B_READ_BUS_n,
   output logic                    o_ALU_WRITE_BUS_n,
   output logic                    o_FLAGS_UPDATE_n,
   output logic [2:0]              o_STEP
);

   localparam logic [OPCODE_WIDTH-1:0] OpLda = OPCODE_WIDTH'(4'h1);
   localparam logic [OPCODE_WIDTH-1:0] OpAdd = OPCODE_WIDTH'(4'h2);
   localparam logic [OPCODE_WIDTH-1:0] OpSub = OPCODE_WIDTH'(4'h3);
   localparam logic [OPCODE_WIDTH-1:0] OpSta = OPCODE_WIDTH'(4'h4);
   localparam logic [OPCODE_WIDTH-1:0] OpLdi = OPCODE_WIDTH'(4'h5);
   localparam logic [OPCODE_WIDTH-1:0] OpJmp = OPCODE_WIDTH'(4'h6);
   localparam logic [OPCODE_WIDTH-1:0] OpJc  = OPCODE_WIDTH'(4'h7);
   localparam logic [OPCODE_WIDTH-1:0] OpJz  = OPCODE_WIDTH'(4'h8);
   localparam logic [OPCODE_WIDTH-1:0] OpOut = OPCODE_WIDTH'(4'hE);
   localparam logic [OPCODE_WIDTH-1:0] OpHlt = OPCODE_WIDTH'(4'hF);

   typedef enum logic [2:0] {
      StT0 = 3'd0,
      StT1 = 3'd1,
      StT2 = 3'd2,
      StT3 = 3'd3,
      StT4 = 3'd4
   } step_e;

   step_e step_q, step_d;
   // Latched once HLT reaches T2 so the halt holds even if the opcode bus wiggles.
   logic  halted_q, halted_d;

   logic mem_instr;   // instructions that go through the MAR (4 or 5 steps)
   logic alu_instr;   // ADD/SUB, the only 5-step instructions
   logic jump_taken;

   assign alu_instr  = (i_OPCODE == OpAdd) || (i_OPCODE == OpSub);
   assign mem_instr  = alu_instr || (i_OPCODE == OpLda) || (i_OPCODE == OpSta);
   assign jump_taken = (i_OPCODE == OpJmp) || ((i_OPCODE == OpJc) && i_CARRY_FLAG) ||
                       ((i_OPCODE == OpJz) && i_ZERO_FLAG);

   // State register
   always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
      if (i_CLEAR) begin
         step_q   <= StT0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   // Next-state logic
   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      case (step_q)
         StT0: step_d = StT1;
         StT1: step_d = StT2;
         StT2: begin
            if (halted_q || (i_OPCODE == OpHlt)) begin
               step_d   = StT2;
               halted_d = 1'b1;
            end else if (mem_instr) begin
               step_d = StT3;
            end else begin
               step_d = StT0;
            end
         end
         StT3:    step_d = alu_instr ? StT4 : StT0;
         StT4:    step_d = StT0;
         default: step_d = StT0;
      endcase
   end

   // Output decode; reset overrides everything so no partial pulse escapes.
   always_comb begin
      o_PC_COUNT_ENABLE = 1'b0;
      o_OUT_READ_BUS    = 1'b0;
      o_ALU_SUBTRACT    = 1'b0;
      o_HALT            = 1'b0;
      o_PC_JUMP_n       = 1'b1;
      o_PC_WRITE_BUS_n  = 1'b1;
      o_MAR_READ_BUS_n  = 1'b1;
      o_RAM_READ_BUS_n  = 1'b1;
      o_RAM_WRITE_BUS_n = 1'b1;
      o_IR_READ_BUS_n   = 1'b1;
      o_IR_WRITE_BUS_n  = 1'b1;
      o_A_READ_BUS_n    = 1'b1;
      o_A_WRITE_BUS_n   = 1'b1;
      o_B_READ_BUS_n    = 1'b1;
      o_ALU_WRITE_BUS_n = 1'b1;
      o_FLAGS_UPDATE_n  = 1'b1;
      if (!i_CLEAR) begin
         if (halted_q) begin
            o_HALT = 1'b1;
         end else begin
            case (step_q)
               StT0: begin
                  o_PC_WRITE_BUS_n = 1'b0;
                  o_MAR_READ_BUS_n = 1'b0;
               end
               StT1: begin
                  o_RAM_WRITE_BUS_n = 1'b0;
                  o_IR_READ_BUS_n   = 1'b0;
                  o_PC_COUNT_ENABLE = 1'b1;
               end
               StT2: begin
                  if (mem_instr) begin
                     o_IR_WRITE_BUS_n = 1'b0;
                     o_MAR_READ_BUS_n = 1'b0;
                  end else if (i_OPCODE == OpLdi) begin
                     o_IR_WRITE_BUS_n = 1'b0;
                     o_A_READ_BUS_n   = 1'b0;
                  end else if (jump_taken) begin
                     o_IR_WRITE_BUS_n = 1'b0;
                     o_PC_JUMP_n      = 1'b0;
                  end else if (i_OPCODE == OpOut) begin
                     o_A_WRITE_BUS_n = 1'b0;
                     o_OUT_READ_BUS  = 1'b1;
                  end else if (i_OPCODE == OpHlt) begin
                     o_HALT = 1'b1;
                  end
               end
               StT3: begin
                  if (alu_instr) begin
                     o_RAM_WRITE_BUS_n = 1'b0;
                     o_B_READ_BUS_n    = 1'b0;
                  end else if (i_OPCODE == OpLda) begin
                     o_RAM_WRITE_BUS_n = 1'b0;
                     o_A_READ_BUS_n    = 1'b0;
                  end else if (i_OPCODE == OpSta) begin
                     o_A_WRITE_BUS_n  = 1'b0;
                     o_RAM_READ_BUS_n = 1'b0;
                  end
               end
               StT4: begin
                  if (alu_instr) begin
                     o_ALU_WRITE_BUS_n = 1'b0;
                     o_A_READ_BUS_n    = 1'b0;
                     o_FLAGS_UPDATE_n  = 1'b0;
                     o_ALU_SUBTRACT    = (i_OPCODE == OpSub);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_STEP = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-scenario tasks with inline checks against a
// micro-op table model (controls expressed as "asserted" bits, polarity-free).
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       clr;
   logic [3:0] op;
   logic       zf, cf;
   logic       pc_ce, out_rd, alu_sub, halt;
   logic       pc_jump_n, pc_wr_n, mar_rd_n, ram_rd_n, ram_wr_n, ir_rd_n, ir_wr_n;
   logic       a_rd_n, a_wr_n, b_rd_n, alu_wr_n, flags_n;
   logic [2:0] step;
   logic [15:0] act;

   int checks   = 0;
   int failures = 0;

   localparam int PcCe = 0, OutRd = 1, AluSub = 2, Halt = 3, PcJump = 4, PcWr = 5;
   localparam int MarRd = 6, RamRd = 7, RamWr = 8, IrRd = 9, IrWr = 10, ARd = 11;
   localparam int AWr = 12, BRd = 13, AluWr = 14, FlagsUp = 15;
   localparam logic [15:0] WrMask = 16'b0101_0101_0010_0000; // PC, RAM, IR, A, ALU writers

   always #5 clk = ~clk;

   assign act = {~flags_n, ~alu_wr_n, ~b_rd_n, ~a_wr_n, ~a_rd_n, ~ir_wr_n, ~ir_rd_n,
                 ~ram_wr_n, ~ram_rd_n, ~mar_rd_n, ~pc_wr_n, ~pc_jump_n, halt, alu_sub,
                 out_rd, pc_ce};

   control_sequencer #(.OPCODE_WIDTH(4)) dut (
      .i_CLOCK          (clk),
      .i_CLEAR          (clr),
      .i_OPCODE         (op),
      .i_ZERO_FLAG      (zf),
      .i_CARRY_FLAG     (cf),
      .o_PC_COUNT_ENABLE(pc_ce),
      .o_OUT_READ_BUS   (out_rd),
      .o_ALU_SUBTRACT   (alu_sub),
      .o_HALT           (halt),
      .o_PC_JUMP_n      (pc_jump_n),
      .o_PC_WRITE_BUS_n (pc_wr_n),
      .o_MAR_READ_BUS_n (mar_rd_n),
      .o_RAM_READ_BUS_n (ram_rd_n),
      .o_RAM_WRITE_BUS_n(ram_wr_n),
      .o_IR_READ_BUS_n  (ir_rd_n),
      .o_IR_WRITE_BUS_n (ir_wr_n),
      .o_A_READ_BUS_n   (a_rd_n),
      .o_A_WRITE_BUS_n  (a_wr_n),
      .o_B_READ_BUS_n   (b_rd_n),
      .o_ALU_WRITE_BUS_n(alu_wr_n),
      .o_FLAGS_UPDATE_n (flags_n),
      .o_STEP           (step)
   );

   // Micro-op table: which controls are asserted in step s of instruction o.
   function automatic logic [15:0] exp_ctrl(input int s, input logic [3:0] o,
                                            input logic z, input logic c);
      logic [15:0] a;
      a = '0;
      case (s)
         0: begin a[PcWr] = 1'b1; a[MarRd] = 1'b1; end
         1: begin a[RamWr] = 1'b1; a[IrRd] = 1'b1; a[PcCe] = 1'b1; end
         2: case (o)
               4'h1, 4'h2, 4'h3, 4'h4: begin a[IrWr] = 1'b1; a[MarRd] = 1'b1; end
               4'h5: begin a[IrWr] = 1'b1; a[ARd] = 1'b1; end
               4'h6: begin a[IrWr] = 1'b1; a[PcJump] = 1'b1; end
               4'h7: if (c) begin a[IrWr] = 1'b1; a[PcJump] = 1'b1; end
               4'h8: if (z) begin a[IrWr] = 1'b1; a[PcJump] = 1'b1; end
               4'hE: begin a[AWr] = 1'b1; a[OutRd] = 1'b1; end
               4'hF: a[Halt] = 1'b1;
               default: ;
            endcase
         3: case (o)
               4'h1: begin a[RamWr] = 1'b1; a[ARd] = 1'b1; end
               4'h2, 4'h3: begin a[RamWr] = 1'b1; a[BRd] = 1'b1; end
               4'h4: begin a[AWr] = 1'b1; a[RamRd] = 1'b1; end
               default: ;
            endcase
         4: if (o == 4'h2 || o == 4'h3) begin
               a[AluWr] = 1'b1; a[ARd] = 1'b1; a[FlagsUp] = 1'b1;
               a[AluSub] = (o == 4'h3);
            end
         default: ;
      endcase
      return a;
   endfunction

   // Cycles per instruction; HLT counts its first T2 only.
   function automatic int instr_len(input logic [3:0] o);
      case (o)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         default:    return 3;
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   // Short reset pulse between edges; leaves the DUT in T0 before the next edge.
   task automatic apply_reset();
      @(posedge clk);
      #2 clr = 1'b1;
      #2 clr = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      op  = 4'($urandom);
      zf  = 1'($urandom);
      cf  = 1'($urandom);
      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (step !== 3'd0) begin
         failures++; $display("FAIL reset_step got=%0d want=0", step);
      end
      checks++;
      if (act !== 16'h0) begin
         failures++; $display("FAIL reset_idle got=%h want=0000", act);
      end
      clr = 1'b0;
      #1;
      checks++;
      if (step !== 3'd0 || act !== exp_ctrl(0, op, zf, cf)) begin
         failures++;
         $display("FAIL reset_t0 step=%0d act=%h want step=0 act=%h", step, act,
                  exp_ctrl(0, op, zf, cf));
      end
      next_cycle();
      #1;
      checks++;
      if (step !== 3'd1 || act !== exp_ctrl(1, op, zf, cf)) begin
         failures++;
         $display("FAIL reset_t1 step=%0d act=%h want step=1 act=%h", step, act,
                  exp_ctrl(1, op, zf, cf));
      end
   endtask

   task automatic test_sub();
      apply_reset();
      op = 4'h3;
      for (int s = 0; s < 5; s++) begin
         zf = 1'($urandom);
         cf = 1'($urandom);
         #1;
         checks++;
         if (step !== 3'(s) || act !== exp_ctrl(s, 4'h3, zf, cf)) begin
            failures++;
            $display("FAIL sub_step%0d step=%0d act=%h want step=%0d act=%h", s, step, act,
                     s, exp_ctrl(s, 4'h3, zf, cf));
         end
         next_cycle();
      end
      #1;
      checks++;
      if (step !== 3'd0) begin
         failures++; $display("FAIL sub_wrap got=%0d want=0", step);
      end
   endtask

   task automatic test_jc();
      for (int c = 0; c < 2; c++) begin
         apply_reset();
         op = 4'h7;
         zf = 1'($urandom);
         next_cycle();
         next_cycle();
         cf = 1'(c);
         #1;
         checks++;
         if (step !== 3'd2 || act !== exp_ctrl(2, 4'h7, zf, cf)) begin
            failures++;
            $display("FAIL jc_t2 carry=%0d step=%0d act=%h want step=2 act=%h", c, step, act,
                     exp_ctrl(2, 4'h7, zf, cf));
         end
         checks++;
         if (pc_jump_n !== ~cf) begin
            failures++; $display("FAIL jc_jump carry=%0d got=%b want=%b", c, pc_jump_n, ~cf);
         end
         next_cycle();
         #1;
         checks++;
         if (step !== 3'd0) begin
            failures++; $display("FAIL jc_wrap got=%0d want=0", step);
         end
      end
   endtask

   task automatic test_halt();
      apply_reset();
      op = 4'hF;
      next_cycle();
      next_cycle();
      for (int i = 0; i < 12; i++) begin
         zf = 1'($urandom);
         cf = 1'($urandom);
         #1;
         checks++;
         if (step !== 3'd2 || act !== exp_ctrl(2, 4'hF, zf, cf)) begin
            failures++;
            $display("FAIL halt_hold cyc=%0d step=%0d act=%h want step=2 act=%h", i, step, act,
                     exp_ctrl(2, 4'hF, zf, cf));
         end
         next_cycle();
      end
      clr = 1'b1;
      #1;
      checks++;
      if (step !== 3'd0 || act !== 16'h0) begin
         failures++; $display("FAIL halt_clear step=%0d act=%h want step=0 act=0000", step, act);
      end
      clr = 1'b0;
      #1;
      checks++;
      if (step !== 3'd0 || act !== exp_ctrl(0, op, zf, cf)) begin
         failures++; $display("FAIL halt_restart step=%0d act=%h", step, act);
      end
      next_cycle();
      #1;
      checks++;
      if (step !== 3'd1) begin
         failures++; $display("FAIL halt_resume got=%0d want=1", step);
      end
   endtask

   task automatic test_clear_mid_add();
      apply_reset();
      op = 4'h2;
      next_cycle();
      next_cycle();
      next_cycle();
      #1;
      checks++;
      if (step !== 3'd3 || act !== exp_ctrl(3, 4'h2, zf, cf)) begin
         failures++; $display("FAIL add_t3 step=%0d act=%h want step=3 act=%h", step, act,
                              exp_ctrl(3, 4'h2, zf, cf));
      end
      clr = 1'b1;
      #1;
      checks++;
      if (step !== 3'd0 || act !== 16'h0) begin
         failures++; $display("FAIL add_abort step=%0d act=%h want step=0 act=0000", step, act);
      end
      @(posedge clk);
      #1;
      checks++;
      if (step !== 3'd0 || act !== 16'h0) begin
         failures++; $display("FAIL add_abort_edge step=%0d act=%h want 0/0000", step, act);
      end
      clr = 1'b0;
      #1;
      checks++;
      if (step !== 3'd0 || act !== exp_ctrl(0, op, zf, cf)) begin
         failures++; $display("FAIL add_restart step=%0d act=%h", step, act);
      end
      next_cycle();
      #1;
      checks++;
      if (step !== 3'd1) begin
         failures++; $display("FAIL add_resume got=%0d want=1", step);
      end
   endtask

   // Runs instructions back to back; opcode is random noise during fetch.
   task automatic test_sweep();
      logic [3:0] ins;
      apply_reset();
      for (int k = 0; k < 16; k++) begin
         ins = 4'(k);
         for (int s = 0; s < instr_len(ins); s++) begin
            op = (s < 2) ? 4'($urandom) : ins;
            zf = 1'($urandom);
            cf = 1'($urandom);
            #1;
            checks++;
            if (step !== 3'(s) || act !== exp_ctrl(s, ins, zf, cf)) begin
               failures++;
               $display("FAIL sweep op=%h step%0d got step=%0d act=%h want act=%h", ins, s,
                        step, act, exp_ctrl(s, ins, zf, cf));
            end
            checks++;
            if ($countones(act & WrMask) > 1) begin
               failures++; $display("FAIL sweep_bus op=%h step=%0d act=%h", ins, s, act);
            end
            next_cycle();
         end
         #1;
         checks++;
         if (step !== ((ins == 4'hF) ? 3'd2 : 3'd0)) begin
            failures++; $display("FAIL sweep_len op=%h step=%0d after %0d cycles", ins, step,
                                 instr_len(ins));
         end
      end
      apply_reset();
   endtask

   task automatic test_back_to_back();
      logic [3:0] ins;
      apply_reset();
      for (int k = 0; k < 40; k++) begin
         ins = 4'($urandom_range(0, 14));
         for (int s = 0; s < instr_len(ins); s++) begin
            op = (s < 2) ? 4'($urandom) : ins;
            zf = 1'($urandom);
            cf = 1'($urandom);
            #1;
            checks++;
            if (step !== 3'(s) || act !== exp_ctrl(s, ins, zf, cf)) begin
               failures++;
               $display("FAIL b2b op=%h step%0d got step=%0d act=%h want act=%h", ins, s,
                        step, act, exp_ctrl(s, ins, zf, cf));
            end
            checks++;
            if ($countones(act & WrMask) > 1) begin
               failures++; $display("FAIL b2b_bus op=%h step=%0d act=%h", ins, s, act);
            end
            next_cycle();
         end
         #1;
         checks++;
         if (step !== 3'd0) begin
            failures++; $display("FAIL b2b_wrap op=%h got=%0d want=0", ins, step);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sub();
      test_jc();
      test_halt();
      test_clear_mid_add();
      test_sweep();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
